// File: rtl/bus_register_bank.sv
// bus_register_bank: register bank with one write port, two combinational read ports,
// an optional hardwired-zero R0 and a flush engine that clears one register per cycle.
module bus_register_bank #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter int                    ADDR_WIDTH = 4,
    parameter bit                    R0_ZERO    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic                  flush_req,
    output logic [DATA_WIDTH-1:0] BusMuxIn,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  wr_drop
);
    typedef enum logic {IDLE, FLUSH} state_t;
    localparam logic [ADDR_WIDTH:0]   NREGS = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_REGS - 1);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  flush_done_q, flush_done_d;
    logic                  wr_drop_q, wr_drop_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   we, clr;
    logic                  out_of_range, last;
    assign out_of_range = {1'b0, wr_addr} >= NREGS;
    assign last         = idx_q == LAST;
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        flush_done_d = 1'b0;
        wr_drop_d    = 1'b0;
        if (state_q == IDLE) begin
            state_d   = flush_req ? FLUSH : IDLE;
            idx_d     = '0;
            wr_drop_d = wr_en && out_of_range;
        end else begin
            state_d      = last ? IDLE : FLUSH;
            idx_d        = last ? '0 : idx_q + 1'b1;
            flush_done_d = last;
            wr_drop_d    = wr_en;
        end
    end
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            flush_done_q <= 1'b0;
            wr_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            flush_done_q <= flush_done_d;
            wr_drop_q    <= wr_drop_d;
        end
    end
    // R0 never accepts bus writes when hardwired, so its flop stays at zero
    always_comb begin
        we  = '0;
        clr = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            we[k]  = state_q == IDLE && wr_en && wr_addr == ADDR_WIDTH'(k) && !(R0_ZERO && k == 0);
            clr[k] = state_q == FLUSH && idx_q == ADDR_WIDTH'(k);
        end
    end
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int k = 0; k < NUM_REGS; k++)
                regs_q[k] <= (R0_ZERO && k == 0) ? '0 : INIT;
        end else begin
            for (int k = 0; k < NUM_REGS; k++)
                if (clr[k]) regs_q[k] <= '0;
                else if (we[k]) regs_q[k] <= BusMuxOut;
        end
    end
    // unmatched addresses (>= NUM_REGS) fall through to zero
    always_comb begin
        BusMuxIn  = '0;
        rd_data_b = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr_a == ADDR_WIDTH'(k)) BusMuxIn = regs_q[k];
            if (rd_addr_b == ADDR_WIDTH'(k)) rd_data_b = regs_q[k];
        end
    end
    assign busy       = state_q == FLUSH;
    assign flush_done = flush_done_q;
    assign wr_drop    = wr_drop_q;
endmodule
